// File: rtl/bsg_adder_cin_pipelined_if.sv
// Operand/result bundle for bsg_adder_cin_pipelined: a valid/ready input side
// and a valid/yumi output side.
// Handshake rules: an operand set transfers on a cycle where v_i & ready_o;
// a result transfers where v_o & yumi_i; yumi_i may only be high while v_o is high.
interface bsg_adder_cin_pipelined_if #(
    parameter int width_p = 32
);
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] a_i;
    logic [width_p-1:0] b_i;
    logic               cin_i;
    logic               v_o;
    logic               yumi_i;
    logic [width_p-1:0] o;
    logic               cout_o;

    modport master (
        output v_i, a_i, b_i, cin_i, yumi_i,
        input  ready_o, v_o, o, cout_o
    );

    modport slave (
        input  v_i, a_i, b_i, cin_i, yumi_i,
        output ready_o, v_o, o, cout_o
    );
endinterface

// File: rtl/bsg_adder_cin_pipelined.sv
// Segmented pipelined adder: each stage adds one seg_w-bit slice using the carry
// registered by the previous stage, with per-stage bubble collapsing.
module bsg_adder_cin_pipelined #(
    parameter int width_p  = 32,
    parameter int stages_p = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    bsg_adder_cin_pipelined_if.slave    io
);
    localparam int seg_w = width_p / stages_p;

    logic [stages_p-1:0] v_all;
    logic [stages_p-1:0] c_all;
    logic [stages_p-1:0] en;
    logic [width_p-1:0]  res_all [stages_p];
    // Operands still to be consumed, shifted so stage k always reads bits [seg_w-1:0].
    logic [width_p-1:0]  a_in    [stages_p];
    logic [width_p-1:0]  b_in    [stages_p];

    // A stage may load when it is empty or when everything downstream moves.
    always_comb begin
        en = '0;
        en[stages_p-1] = ~v_all[stages_p-1] | io.yumi_i;
        for (int k = stages_p - 2; k >= 0; k--) begin
            en[k] = ~v_all[k] | en[k+1];
        end
    end

    assign io.ready_o = en[0] & ~reset_i;
    assign io.v_o     = v_all[stages_p-1];
    assign io.o       = res_all[stages_p-1];
    assign io.cout_o  = c_all[stages_p-1];

    assign a_in[0] = io.a_i;
    assign b_in[0] = io.b_i;

    for (genvar k = 0; k < stages_p; k++) begin : g_stage
        logic               v_src;
        logic               c_src;
        logic [width_p-1:0] res_src;
        logic [width_p-1:0] res_d;
        logic [seg_w:0]     seg_sum;
        logic               v_q;
        logic               c_q;
        logic [width_p-1:0] res_q;

        if (k == 0) begin : g_head
            assign v_src   = io.v_i & io.ready_o;
            assign c_src   = io.cin_i;
            assign res_src = '0;
        end else begin : g_body
            assign v_src   = v_all[k-1];
            assign c_src   = c_all[k-1];
            assign res_src = res_all[k-1];
        end

        assign seg_sum = {1'b0, a_in[k][seg_w-1:0]} + {1'b0, b_in[k][seg_w-1:0]}
                       + {{seg_w{1'b0}}, c_src};

        always_comb begin
            res_d = res_src;
            res_d[k*seg_w +: seg_w] = seg_sum[seg_w-1:0];
        end

        // Data only moves with a valid token; a bubble leaves the old contents in place.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (en[k]) begin
                v_q <= v_src;
                if (v_src) begin
                    c_q   <= seg_sum[seg_w];
                    res_q <= res_d;
                end
            end
        end

        assign v_all[k]   = v_q;
        assign c_all[k]   = c_q;
        assign res_all[k] = res_q;

        if (k < stages_p - 1) begin : g_ops
            logic [width_p-1:0] a_q;
            logic [width_p-1:0] b_q;

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en[k] && v_src) begin
                    a_q <= a_in[k] >> seg_w;
                    b_q <= b_in[k] >> seg_w;
                end
            end

            assign a_in[k+1] = a_q;
            assign b_in[k+1] = b_q;
        end
    end
endmodule

// File: tb/tb_bsg_adder_cin_pipelined.sv
// Bench for bsg_adder_cin_pipelined: directed scenarios on a 32-bit/4-stage instance
// plus random streaming on 1/2/8-stage and 64-bit instances.
module tb_bsg_adder_cin_pipelined;
    localparam int W = 32;
    localparam int S = 4;
    localparam int N_CFG = 4;
    localparam int CFG_OPS = 2000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bsg_adder_cin_pipelined_if #(.width_p(W)) bus();
    bsg_adder_cin_pipelined #(.width_p(W), .stages_p(S)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (bus)
    );

    int          total;
    int          bad;
    int          popped;
    logic [W:0]  exp_q[$];
    logic [W:0]  mon_exp;
    logic        cfg_start;
    int          cfg_done;

    // Scoreboard: every output transfer is checked against the oldest expected result.
    always @(negedge clk) begin
        #2;
        if (!reset && bus.yumi_i === 1'b1 && bus.v_o !== 1'b1) begin
            bad++;
            $display("FAIL yumi_without_valid: yumi_i=1 v_o=%b, required v_o=1", bus.v_o);
        end
        if (!reset && bus.v_o === 1'b1 && bus.yumi_i === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got cout=%b o=%h, required no result", bus.cout_o, bus.o);
            end else begin
                mon_exp = exp_q.pop_front();
                popped++;
                if ({bus.cout_o, bus.o} !== mon_exp) begin
                    bad++;
                    $display("FAIL result_order: got %h, required %h", {bus.cout_o, bus.o}, mon_exp);
                end
            end
        end
    end

    task automatic drive(input logic vin, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic want_y, output logic acc);
        @(negedge clk);
        bus.v_i    = vin;
        bus.a_i    = a;
        bus.b_i    = b;
        bus.cin_i  = cin;
        bus.yumi_i = want_y & bus.v_o;
        #1;
        acc = vin & bus.ready_o;
        if (acc) exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
    endtask

    task automatic drain(input string name);
        logic acc;
        int   n;
        n = 0;
        while ((exp_q.size() != 0 || bus.v_o) && n < 200) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d results still missing after %0d cycles, required 0", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic acc;
        reset       = 1'b1;
        bus.v_i     = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.cin_i   = 1'b0;
        bus.yumi_i  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total += 4;
        if (bus.v_o !== 1'b0) begin bad++; $display("FAIL reset_v_o: got %b required 0", bus.v_o); end
        if (bus.o !== '0) begin bad++; $display("FAIL reset_o: got %h required 0", bus.o); end
        if (bus.cout_o !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b required 0", bus.cout_o); end
        if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b required 0", bus.ready_o); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b required 1", bus.ready_o); end

        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'h1111_1111 * i, 32'h0F0F_0F0F, 1'b1, 1'b0, acc);
            total++;
            if (acc !== 1'b1) begin bad++; $display("FAIL midstream_accept%0d: got %b required 1", i, acc); end
        end
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
        total++;
        if (bus.v_o !== 1'b1) begin bad++; $display("FAIL midstream_valid: got %b required 1", bus.v_o); end
        reset = 1'b1;
        #1;
        total += 4;
        if (bus.v_o !== 1'b0) begin bad++; $display("FAIL async_reset_v_o: got %b required 0", bus.v_o); end
        if (bus.o !== '0) begin bad++; $display("FAIL async_reset_o: got %h required 0", bus.o); end
        if (bus.cout_o !== 1'b0) begin bad++; $display("FAIL async_reset_cout: got %b required 0", bus.cout_o); end
        if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL async_reset_ready: got %b required 0", bus.ready_o); end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
            total++;
            if (bus.v_o !== 1'b0) begin bad++; $display("FAIL discarded_result%0d: got v_o=%b required 0", i, bus.v_o); end
        end
    endtask

    task automatic test_carry_cross();
        logic acc;
        drive(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL carry_accept: got %b required 1", acc); end
        for (int i = 1; i <= S; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
            total++;
            if (bus.v_o !== (i == S)) begin
                bad++;
                $display("FAIL latency_cycle%0d: got v_o=%b required %b", i, bus.v_o, (i == S));
            end
        end
        total++;
        if ({bus.cout_o, bus.o} !== 33'h0_0001_0000) begin
            bad++;
            $display("FAIL carry_cross: got %h required 0_00010000", {bus.cout_o, bus.o});
        end
        drain("carry");
    endtask

    task automatic test_wraparound();
        logic acc;
        int   seen;
        seen = 0;
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, acc);
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, acc);
        for (int n = 0; n < 12 && seen < 2; n++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1, acc);
            if (bus.v_o === 1'b1) begin
                total++;
                if (seen == 0 && {bus.cout_o, bus.o} !== 33'h1_0000_0000) begin
                    bad++;
                    $display("FAIL wrap_all_ones: got %h required 1_00000000", {bus.cout_o, bus.o});
                end
                if (seen == 1 && {bus.cout_o, bus.o} !== 33'h1_0000_0001) begin
                    bad++;
                    $display("FAIL wrap_msb: got %h required 1_00000001", {bus.cout_o, bus.o});
                end
                seen++;
            end
        end
        total++;
        if (seen != 2) begin bad++; $display("FAIL wrap_count: got %0d results required 2", seen); end
        drain("wrap");
    endtask

    task automatic test_stall_fill();
        logic       acc;
        int         acc_cnt;
        logic [W:0] held;
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b0, acc);
            acc_cnt += int'(acc);
        end
        total += 4;
        if (acc_cnt != S) begin bad++; $display("FAIL fill_accepts: got %0d required %0d", acc_cnt, S); end
        if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL full_ready: got %b required 0", bus.ready_o); end
        if (bus.v_o !== 1'b1) begin bad++; $display("FAIL full_valid: got %b required 1", bus.v_o); end
        held = {bus.cout_o, bus.o};
        if (exp_q.size() == 0 || held !== exp_q[0]) begin
            bad++;
            $display("FAIL stalled_head: got %h required %h", held, (exp_q.size() != 0) ? exp_q[0] : '0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom(), $urandom(), 1'b0, 1'b0, acc);
            total++;
            if ({bus.cout_o, bus.o} !== held || bus.v_o !== 1'b1 || acc !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: got v=%b res=%h acc=%b required v=1 res=%h acc=0",
                         i, bus.v_o, {bus.cout_o, bus.o}, acc, held);
            end
        end
        for (int i = 0; i < S; i++) begin
            drive(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'b1, acc);
            total++;
            if (acc !== 1'b1 || bus.v_o !== 1'b1) begin
                bad++;
                $display("FAIL full_passthrough%0d: got acc=%b v_o=%b required 1 1", i, acc, bus.v_o);
            end
        end
        drain("stall");
    endtask

    task automatic test_back_to_back();
        logic       acc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int         issued;
        int         start_pop;
        int         cyc;
        issued    = 0;
        start_pop = popped;
        cyc       = 0;
        while (issued < 10000 && cyc < 60000) begin
            a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom());
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom());
            drive($urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
            issued += int'(acc);
            cyc++;
        end
        drain("stream");
        total += 2;
        if (issued != 10000) begin bad++; $display("FAIL stream_issued: got %0d required 10000", issued); end
        if (popped - start_pop != issued) begin
            bad++;
            $display("FAIL stream_count: got %0d results required %0d", popped - start_pop, issued);
        end
    endtask

    task automatic test_configs();
        int n;
        n = 0;
        cfg_start = 1'b1;
        while (cfg_done < N_CFG && n < 60000) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (cfg_done != N_CFG) begin bad++; $display("FAIL configs_done: got %0d required %0d", cfg_done, N_CFG); end
    endtask

    for (genvar g = 0; g < N_CFG; g++) begin : g_cfg
        localparam int CW = (g == 3) ? 64 : 32;
        localparam int CS = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 4;

        bsg_adder_cin_pipelined_if #(.width_p(CW)) cbus();
        bsg_adder_cin_pipelined #(.width_p(CW), .stages_p(CS)) cdut (
            .clk_i   (clk),
            .reset_i (reset),
            .io      (cbus)
        );

        logic [CW:0] cq[$];

        initial begin : run
            int          issued;
            int          got;
            int          cyc;
            logic [63:0] ra;
            logic [63:0] rb;
            logic [CW:0] e;
            cbus.v_i   = 1'b0;
            cbus.a_i   = '0;
            cbus.b_i   = '0;
            cbus.cin_i = 1'b0;
            cbus.yumi_i = 1'b0;
            wait (cfg_start === 1'b1);
            issued = 0;
            got    = 0;
            cyc    = 0;
            while ((issued < CFG_OPS || cq.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                ra = {$urandom(), $urandom()};
                rb = {$urandom(), $urandom()};
                if ($urandom_range(0, 7) == 0) ra = '1;
                cbus.v_i    = (issued < CFG_OPS) && ($urandom_range(0, 3) != 0);
                cbus.a_i    = ra[CW-1:0];
                cbus.b_i    = rb[CW-1:0];
                cbus.cin_i  = 1'($urandom_range(0, 1));
                cbus.yumi_i = ($urandom_range(0, 3) != 0) & cbus.v_o;
                #1;
                if (cbus.v_o && cbus.yumi_i) begin
                    total++;
                    got++;
                    if (cq.size() == 0) begin
                        bad++;
                        $display("FAIL cfg%0d_unexpected: got %h required no result", g, {cbus.cout_o, cbus.o});
                    end else begin
                        e = cq.pop_front();
                        if ({cbus.cout_o, cbus.o} !== e) begin
                            bad++;
                            $display("FAIL cfg%0d_result: got %h required %h", g, {cbus.cout_o, cbus.o}, e);
                        end
                    end
                end
                if (cbus.v_i && cbus.ready_o) begin
                    cq.push_back({1'b0, cbus.a_i} + {1'b0, cbus.b_i} + {{CW{1'b0}}, cbus.cin_i});
                    issued++;
                end
                cyc++;
            end
            total++;
            if (got != CFG_OPS || cq.size() != 0) begin
                bad++;
                $display("FAIL cfg%0d_count: got %0d results (%0d pending) required %0d", g, got, cq.size(), CFG_OPS);
            end
            cbus.v_i    = 1'b0;
            cbus.yumi_i = 1'b0;
            cfg_done++;
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        popped    = 0;
        cfg_start = 1'b0;
        cfg_done  = 0;
        reset     = 1'b1;
        test_reset();
        test_carry_cross();
        test_wraparound();
        test_stall_fill();
        test_back_to_back();
        test_configs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
